pll_lock_supervisor: RTL and testbench

Supervises the board PLL from its free-running reference clock: holds the PLL in reset for a fixed pulse, waits for `locked` within a timeout, and qualifies lock over a stability window. On timeout or lock loss it pulses the PLL reset again and retries. It drives the PLL `areset` input that the clock generator currently ties low, and reports stable-lock, failure and retry status to board logic.

---
 rtl/pll_lock_supervisor_if.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 133 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Status and control signals between the PLL lock supervisor and the PLL/board logic.
// The supervisor takes the master modport; the board/PLL side takes the slave modport.
interface pll_lock_supervisor_if;
    logic       i_locked;
    logic       o_pll_areset;
    logic       o_stable;
    logic       o_fail;
    logic [7:0] o_retries;

    modport master (
        input  i_locked,
        output o_pll_areset,
        output o_stable,
        output o_fail,
        output o_retries
    );

    modport slave (
        output i_locked,
        input  o_pll_areset,
        input  o_stable,
        input  o_fail,
        input  o_retries
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses areset, waits for lock with a timeout, qualifies
// lock over a stability window, and retries a bounded number of times before failing.
module pll_lock_supervisor #(
    parameter int AR_CYCLES     = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pll_lock_supervisor_if.master bus
);

    localparam int MAX_AW  = (AR_CYCLES > LOCK_TIMEOUT) ? AR_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AW > STABLE_CYCLES) ? MAX_AW : STABLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_AR,
        ST_WAIT,
        ST_QUAL,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       retries;
    logic             areset_q;
    logic             stable_q;
    logic             fail_q;
    logic             locked_m;
    logic             locked_s;
    logic             attempt_failed;

    // NOTE: non-blocking assignments let the two stages shift together on one edge;
    // blocking ones would collapse the synchronizer into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= bus.i_locked;
            locked_s <= locked_m;
        end
    end

    // An attempt ends badly on a lock timeout (lock on that same cycle still wins)
    // or on any single low sample while qualifying.
    assign attempt_failed = ((state == ST_WAIT) && !locked_s && (cnt == TIMEOUT_LAST)) ||
                            ((state == ST_QUAL) && !locked_s);

    // Outputs are registered alongside each transition so they decode the new state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_AR;
            cnt      <= '0;
            retries  <= 8'd0;
            areset_q <= 1'b1;
            stable_q <= 1'b0;
            fail_q   <= 1'b0;
        end else if (attempt_failed) begin
            cnt      <= '0;
            areset_q <= 1'b1;
            if (retries == RETRY_LIMIT) begin
                state  <= ST_FAIL;
                fail_q <= 1'b1;
            end else begin
                state   <= ST_AR;
                retries <= retries + 8'd1;
            end
        end else begin
            unique case (state)
                ST_AR: begin
                    if (cnt == AR_LAST) begin
                        state    <= ST_WAIT;
                        cnt      <= '0;
                        areset_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (locked_s) begin
                        state <= ST_QUAL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_QUAL: begin
                    if (cnt == STABLE_LAST) begin
                        state    <= ST_LOCKED;
                        cnt      <= '0;
                        stable_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Losing lock after qualification starts a fresh recovery sequence.
                    if (!locked_s) begin
                        state    <= ST_AR;
                        cnt      <= '0;
                        retries  <= 8'd0;
                        areset_q <= 1'b1;
                        stable_q <= 1'b0;
                    end
                end
                ST_FAIL: begin
                end
                default: begin
                    state    <= ST_AR;
                    cnt      <= '0;
                    areset_q <= 1'b1;
                    stable_q <= 1'b0;
                    fail_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_pll_areset = areset_q;
    assign bus.o_stable     = stable_q;
    assign bus.o_fail       = fail_q;
    assign bus.o_retries    = retries;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase-level reference model predicts
// every post-edge output, the driver queues predictions, a monitor pops and compares.
module tb_pll_lock_supervisor;

    localparam int AR   = 16;
    localparam int TO   = 1000;
    localparam int ST   = 64;
    localparam int MR   = 3;
    localparam int MAXN = 4400;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .AR_CYCLES    (AR),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES  (MR)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       areset;
        logic       stable;
        logic       fail;
        logic [7:0] retries;
    } obs_t;

    typedef struct {
        obs_t o;
        int   scen;
        int   edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   lk_a  [MAXN+1];
    obs_t exp_a [MAXN+1];

    // locked_s after edge k reflects i_locked sampled at edge k-1 (0 right after reset)
    function automatic bit ls(int k);
        return (k >= 2) ? lk_a[k-1] : 1'b0;
    endfunction

    // Expected outputs after edges a .. b-1, clipped to 1..n
    task automatic fill(int n, int a, int b, bit ar, bit st, bit fl, int r);
        for (int k = (a < 1) ? 1 : a; k < b && k <= n; k++)
            exp_a[k] = {ar, st, fl, 8'(r)};
    endtask

    // Reference model: walks the lock waveform attempt by attempt, locating the
    // edge at which each phase ends by searching the synchronized lock samples.
    task automatic model(int n);
        int t, r, w, q, f, l, e;
        bit found, failed;
        t = 0;
        r = 0;
        while (t < n) begin
            fill(n, t, t + AR, 1'b1, 1'b0, 1'b0, r);
            w = t + AR;
            found = 1'b0;
            failed = 1'b0;
            q = 0;
            f = 0;
            for (int i = 0; i < TO && w + i <= n; i++)
                if (ls(w + i)) begin
                    q = w + 1 + i;
                    found = 1'b1;
                    break;
                end
            if (!found) begin
                f = w + TO;
                fill(n, w, f, 1'b0, 1'b0, 1'b0, r);
                failed = 1'b1;
            end else begin
                fill(n, w, q, 1'b0, 1'b0, 1'b0, r);
                for (int j = 0; j < ST && q + j <= n; j++)
                    if (!ls(q + j)) begin
                        f = q + 1 + j;
                        failed = 1'b1;
                        break;
                    end
                if (failed) begin
                    fill(n, q, f, 1'b0, 1'b0, 1'b0, r);
                end else begin
                    l = q + ST;
                    fill(n, q, l, 1'b0, 1'b0, 1'b0, r);
                    e = l;
                    while (e <= n && ls(e)) e++;
                    fill(n, l, e + 1, 1'b0, 1'b1, 1'b0, r);
                    t = e + 1;
                    r = 0;
                end
            end
            if (failed) begin
                if (r == MR) begin
                    fill(n, f, n + 1, 1'b1, 1'b0, 1'b1, r);
                    t = n + 1;
                end else begin
                    r++;
                    t = f;
                end
            end
        end
    endtask

    task automatic check(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got areset=%0b stable=%0b fail=%0b retries=%0d, expected areset=%0b stable=%0b fail=%0b retries=%0d",
                     name, act.areset, act.stable, act.fail, act.retries,
                     exp.areset, exp.stable, exp.fail, exp.retries);
        end
    endtask

    always @(posedge i_clk) begin
        exp_t x;
        obs_t act;
        #1;
        if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            act = {bus.o_pll_areset, bus.o_stable, bus.o_fail, bus.o_retries};
            check($sformatf("scen%0d_edge%0d", x.scen, x.edge_n), act, x.o);
        end
    end

    // Two reset cycles (with random i_locked to exercise the synchronizer reset),
    // then n edges driven from lk_a; every edge queues its prediction.
    task automatic run(int scen, int n);
        exp_t tmp;
        model(n);
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            i_rst = 1'b1;
            bus.i_locked = 1'($urandom_range(0, 1));
            tmp.o = {1'b1, 1'b0, 1'b0, 8'd0};
            tmp.scen = scen;
            tmp.edge_n = 0;
            exp_q.push_back(tmp);
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge i_clk);
            i_rst = 1'b0;
            bus.i_locked = lk_a[k];
            tmp.o = exp_a[k];
            tmp.scen = scen;
            tmp.edge_n = k;
            exp_q.push_back(tmp);
        end
    endtask

    task automatic set_lk(int a, int b, bit v);
        for (int k = a; k <= b; k++) lk_a[k] = v;
    endtask

    initial begin
        int k;
        int len;
        int sel;
        bit v;
        bus.i_locked = 1'b0;

        // Nominal lock with i_locked high throughout
        set_lk(1, 150, 1'b1);
        run(0, 150);

        // Never locks: retries 1,2,3 then terminal FAIL
        set_lk(1, 4200, 1'b0);
        run(1, 4200);

        // Reset lands while in FAIL; then stop mid-WAIT of the third attempt (retries=2)
        set_lk(1, 2548, 1'b0);
        run(2, 2548);

        // Reset mid-WAIT; then a one-cycle glitch during qualification
        set_lk(1, 16, 1'b0);
        set_lk(17, 46, 1'b1);
        set_lk(47, 47, 1'b0);
        set_lk(48, 300, 1'b1);
        run(3, 300);

        // Two failed attempts, lock on the third, lock loss, re-qualification
        set_lk(1, 2059, 1'b0);
        set_lk(2060, 2199, 1'b1);
        set_lk(2200, 2202, 1'b0);
        set_lk(2203, 2400, 1'b1);
        run(4, 2400);

        // locked_s first high on the timeout cycle of the first WAIT
        set_lk(1, 1013, 1'b0);
        set_lk(1014, 1150, 1'b1);
        run(5, 1150);

        // One edge later: lock arrives too late and costs a retry
        set_lk(1, 1014, 1'b0);
        set_lk(1015, 1200, 1'b1);
        run(6, 1200);

        // Random lock waveforms mixing short glitches, medium and timeout-length segments
        for (int s = 0; s < 6; s++) begin
            v = 1'($urandom_range(0, 1));
            k = 1;
            while (k <= 3000) begin
                sel = $urandom_range(0, 9);
                len = (sel < 6) ? $urandom_range(1, 40) :
                      (sel < 8) ? $urandom_range(50, 120) : $urandom_range(900, 1100);
                for (int j = 0; j < len && k <= 3000; j++) begin
                    lk_a[k] = v;
                    k++;
                end
                v = !v;
            end
            run(10 + s, 3000);
        end

        repeat (2) @(posedge i_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending predictions, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
